// File: rtl/ifu_ift2bus_pkg.sv
// ifu_ift2bus_pkg: shared fetch-interface sizes and helpers for ifu_ift2bus
package ifu_ift2bus_pkg;
  localparam int E203_PC_SIZE = 32;
  localparam int E203_INSTR_SIZE = 32;
  localparam int E203_IFT_OUTS_DEPTH = 2;
  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction
endpackage

// File: rtl/ifu_ift_rspfifo.sv
// ifu_ift_rspfifo: in-order response buffer of DEPTH entries (DEPTH power of 2)
module ifu_ift_rspfifo #(
  parameter int W = 33,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr, rptr;
  logic [W-1:0] mem [DEPTH];
  // extra pointer bit separates full from empty when the slot indices match
  assign empty = wptr == rptr;
  assign full = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
  assign rdata = mem[rptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      assert (!(push && full && !pop));
      assert (!(pop && empty));
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/ifu_ift2bus.sv
// ifu_ift2bus: ifetch-to-bus bridge with outstanding tracking and in-order response buffer.
// Define E203_IFT_RSP_BYPASS_EN for a zero-latency response path when the buffer is empty.
module ifu_ift2bus
  import ifu_ift2bus_pkg::*;
#(
  parameter int PC_SIZE = E203_PC_SIZE,
  parameter int INSTR_SIZE = E203_INSTR_SIZE,
  parameter int OUTS_DEPTH = E203_IFT_OUTS_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [PC_SIZE-1:0]    ifu_req_pc,
  output logic                  ifu_rsp_valid,
  input  logic                  ifu_rsp_ready,
  output logic                  ifu_rsp_err,
  output logic [INSTR_SIZE-1:0] ifu_rsp_instr,
  output logic                  bus_cmd_valid,
  input  logic                  bus_cmd_ready,
  output logic [PC_SIZE-1:0]    bus_cmd_addr,
  input  logic                  bus_rsp_valid,
  output logic                  bus_rsp_ready,
  input  logic                  bus_rsp_err,
  input  logic [INSTR_SIZE-1:0] bus_rsp_rdata,
  output logic                  ifu_no_outs
);
  localparam int CW = $clog2(OUTS_DEPTH) + 1;
  logic [CW-1:0] outs_cnt;
  logic aligned, has_room, req_hsk, rsp_hsk, mis_hsk, bus_hsk;
  logic fifo_full, fifo_empty, push, pop;
  logic [INSTR_SIZE:0] wdata, rdata;
  assign aligned = is_aligned(ifu_req_pc[1:0]);
  assign has_room = outs_cnt < CW'(OUTS_DEPTH);
  assign ifu_no_outs = outs_cnt == '0;
  // a misaligned fetch only enters an idle pipe so its error keeps program order
  assign ifu_req_ready = has_room & (aligned ? bus_cmd_ready : ifu_no_outs);
  assign bus_cmd_valid = ifu_req_valid & aligned & has_room;
  assign bus_cmd_addr = ifu_req_pc;
  assign req_hsk = ifu_req_valid & ifu_req_ready;
  assign mis_hsk = req_hsk & ~aligned;
  assign bus_rsp_ready = ~fifo_full;
  assign bus_hsk = bus_rsp_valid & bus_rsp_ready & ~ifu_no_outs;
  assign rsp_hsk = ifu_rsp_valid & ifu_rsp_ready;
  assign wdata = mis_hsk ? {1'b1, {INSTR_SIZE{1'b0}}} : {bus_rsp_err, bus_rsp_rdata};
`ifdef E203_IFT_RSP_BYPASS_EN
  assign ifu_rsp_valid = ~fifo_empty | bus_hsk;
  assign {ifu_rsp_err, ifu_rsp_instr} = fifo_empty ? {bus_rsp_err, bus_rsp_rdata} : rdata;
  assign push = mis_hsk | (bus_hsk & ~(fifo_empty & ifu_rsp_ready));
  assign pop = rsp_hsk & ~fifo_empty;
`else
  assign ifu_rsp_valid = ~fifo_empty;
  assign {ifu_rsp_err, ifu_rsp_instr} = rdata;
  assign push = mis_hsk | bus_hsk;
  assign pop = rsp_hsk;
`endif
  always_ff @(posedge clk) begin
    if (rst) outs_cnt <= '0;
    else begin
      if (req_hsk != rsp_hsk) outs_cnt <= req_hsk ? outs_cnt + 1'b1 : outs_cnt - 1'b1;
      assert (!(bus_rsp_valid && ifu_no_outs));
    end
  end
  ifu_ift_rspfifo #(.W(INSTR_SIZE + 1), .DEPTH(OUTS_DEPTH)) u_rspfifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .wdata(wdata),
    .rdata(rdata), .full(fifo_full), .empty(fifo_empty)
  );
endmodule

// File: tb/tb_ifu_ift2bus.sv
// tb_ifu_ift2bus: directed scenarios plus randomized traffic against a queue-based reference model
module tb_ifu_ift2bus;
`ifdef E203_IFT_RSP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic ifu_req_valid = 1'b0, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready = 1'b0, ifu_rsp_err, ifu_no_outs;
  logic [31:0] ifu_req_pc = '0, ifu_rsp_instr, bus_cmd_addr, bus_rsp_rdata = '0;
  logic bus_cmd_valid, bus_cmd_ready = 1'b0, bus_rsp_valid = 1'b0, bus_rsp_ready, bus_rsp_err = 1'b0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  ifu_ift2bus dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_err(ifu_rsp_err),
    .ifu_rsp_instr(ifu_rsp_instr),
    .bus_cmd_valid(bus_cmd_valid), .bus_cmd_ready(bus_cmd_ready), .bus_cmd_addr(bus_cmd_addr),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_ready(bus_rsp_ready), .bus_rsp_err(bus_rsp_err),
    .bus_rsp_rdata(bus_rsp_rdata), .ifu_no_outs(ifu_no_outs)
  );

  function automatic logic [31:0] dataf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_1357;
  endfunction

  function automatic logic errf(input logic [31:0] a);
    return a[5] & a[9];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifu_req_valid = 1'b0; ifu_req_pc = '0; bus_cmd_ready = 1'b0; ifu_rsp_ready = 1'b0;
    bus_rsp_valid = 1'b0; bus_rsp_rdata = '0; bus_rsp_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); tick(); tick();
    checks++; if (ifu_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", ifu_rsp_valid); end
    checks++; if (ifu_no_outs !== 1'b1) begin failures++; $display("FAIL reset_no_outs got=%b exp=1", ifu_no_outs); end
    checks++; if (bus_rsp_ready !== 1'b1) begin failures++; $display("FAIL reset_bus_rsp_ready got=%b exp=1", bus_rsp_ready); end
    checks++; if (bus_cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid_idle got=%b exp=0", bus_cmd_valid); end
    ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0000; #1;
    checks++; if (bus_cmd_valid !== 1'b1) begin failures++; $display("FAIL reset_cmd_valid_req got=%b exp=1", bus_cmd_valid); end
    checks++; if (ifu_req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready_busy got=%b exp=0", ifu_req_ready); end
    bus_cmd_ready = 1'b1; #1;
    checks++; if (ifu_req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", ifu_req_ready); end
    tick(); idle(); rst = 1'b0; #1;
    checks++; if (ifu_no_outs !== 1'b1) begin failures++; $display("FAIL reset_dominates got=%b exp=1", ifu_no_outs); end
  endtask

  task automatic test_aligned();
    idle(); bus_cmd_ready = 1'b1; ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0000; #1;
    checks++; if (bus_cmd_valid !== 1'b1) begin failures++; $display("FAIL aligned_cmd_valid got=%b exp=1", bus_cmd_valid); end
    checks++; if (bus_cmd_addr !== 32'h8000_0000) begin failures++; $display("FAIL aligned_cmd_addr got=%h exp=80000000", bus_cmd_addr); end
    checks++; if (ifu_req_ready !== 1'b1) begin failures++; $display("FAIL aligned_req_ready got=%b exp=1", ifu_req_ready); end
    tick();
    ifu_req_valid = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h0000_0013; #1;
    checks++; if (ifu_rsp_valid !== BYP) begin failures++; $display("FAIL aligned_latency got=%b exp=%b", ifu_rsp_valid, BYP); end
    tick();
    bus_rsp_valid = 1'b0; #1;
    checks++; if (ifu_rsp_valid !== 1'b1) begin failures++; $display("FAIL aligned_rsp_valid got=%b exp=1", ifu_rsp_valid); end
    checks++; if ({ifu_rsp_err, ifu_rsp_instr} !== 33'h0_0000_0013) begin failures++; $display("FAIL aligned_rsp_data got=%b/%h exp=0/00000013", ifu_rsp_err, ifu_rsp_instr); end
    ifu_rsp_ready = 1'b1; tick(); ifu_rsp_ready = 1'b0; #1;
    checks++; if (ifu_no_outs !== 1'b1 || ifu_rsp_valid !== 1'b0) begin failures++; $display("FAIL aligned_drain got=%b/%b exp=1/0", ifu_no_outs, ifu_rsp_valid); end
  endtask

  task automatic test_misaligned();
    idle(); bus_cmd_ready = 1'b1; ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0002; #1;
    checks++; if (bus_cmd_valid !== 1'b0) begin failures++; $display("FAIL mis_cmd_valid got=%b exp=0", bus_cmd_valid); end
    checks++; if (ifu_req_ready !== 1'b1) begin failures++; $display("FAIL mis_req_ready_idle got=%b exp=1", ifu_req_ready); end
    tick();
    checks++; if (ifu_rsp_valid !== 1'b1 || ifu_rsp_err !== 1'b1 || ifu_rsp_instr !== 32'h0) begin failures++; $display("FAIL mis_rsp got=%b/%b/%h exp=1/1/00000000", ifu_rsp_valid, ifu_rsp_err, ifu_rsp_instr); end
    checks++; if (ifu_req_ready !== 1'b0) begin failures++; $display("FAIL mis_req_ready_busy got=%b exp=0", ifu_req_ready); end
    checks++; if (bus_cmd_valid !== 1'b0) begin failures++; $display("FAIL mis_cmd_valid_busy got=%b exp=0", bus_cmd_valid); end
    ifu_req_valid = 1'b0; ifu_rsp_ready = 1'b1; tick(); ifu_rsp_ready = 1'b0; #1;
    checks++; if (ifu_no_outs !== 1'b1) begin failures++; $display("FAIL mis_drain got=%b exp=1", ifu_no_outs); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3];
    a[0] = 32'h8000_0100; a[1] = 32'h8000_0104; a[2] = 32'h8000_0108;
    idle(); bus_cmd_ready = 1'b1; ifu_req_valid = 1'b1; ifu_req_pc = a[0]; #1;
    checks++; if (ifu_req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0 got=%b exp=1", ifu_req_ready); end
    tick();
    ifu_req_pc = a[1]; bus_rsp_valid = 1'b1; bus_rsp_rdata = dataf(a[0]); #1;
    checks++; if (ifu_req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%b exp=1", ifu_req_ready); end
    tick();
    ifu_req_pc = a[2]; bus_rsp_rdata = dataf(a[1]); #1;
    checks++; if (ifu_req_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall got=%b exp=0", ifu_req_ready); end
    tick();
    bus_rsp_valid = 1'b0; #1;
    checks++; if (ifu_req_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_hold got=%b exp=0", ifu_req_ready); end
    checks++; if (ifu_rsp_instr !== dataf(a[0])) begin failures++; $display("FAIL b2b_order0 got=%h exp=%h", ifu_rsp_instr, dataf(a[0])); end
    ifu_rsp_ready = 1'b1; tick();
    ifu_rsp_ready = 1'b0; #1;
    checks++; if (ifu_req_ready !== 1'b1) begin failures++; $display("FAIL b2b_unstall got=%b exp=1", ifu_req_ready); end
    checks++; if (ifu_rsp_instr !== dataf(a[1])) begin failures++; $display("FAIL b2b_order1 got=%h exp=%h", ifu_rsp_instr, dataf(a[1])); end
    tick();
    ifu_req_valid = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = dataf(a[2]); tick();
    bus_rsp_valid = 1'b0; ifu_rsp_ready = 1'b1; #1;
    checks++; if (ifu_rsp_instr !== dataf(a[1])) begin failures++; $display("FAIL b2b_order1b got=%h exp=%h", ifu_rsp_instr, dataf(a[1])); end
    tick();
    checks++; if (ifu_rsp_instr !== dataf(a[2])) begin failures++; $display("FAIL b2b_order2 got=%h exp=%h", ifu_rsp_instr, dataf(a[2])); end
    tick(); ifu_rsp_ready = 1'b0; #1;
    checks++; if (ifu_no_outs !== 1'b1) begin failures++; $display("FAIL b2b_drain got=%b exp=1", ifu_no_outs); end
  endtask

  task automatic fill_two(input logic [31:0] p0, input logic [31:0] p1, input logic e1);
    idle(); bus_cmd_ready = 1'b1; ifu_req_valid = 1'b1; ifu_req_pc = p0; tick();
    ifu_req_pc = p1; bus_rsp_valid = 1'b1; bus_rsp_rdata = dataf(p0); bus_rsp_err = 1'b0; tick();
    ifu_req_valid = 1'b0; bus_rsp_rdata = dataf(p1); bus_rsp_err = e1; tick();
    bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
  endtask

  task automatic test_err();
    fill_two(32'h8000_0200, 32'h8000_0204, 1'b1);
    ifu_rsp_ready = 1'b1; #1;
    checks++; if ({ifu_rsp_err, ifu_rsp_instr} !== {1'b0, dataf(32'h8000_0200)}) begin failures++; $display("FAIL err_first got=%b/%h exp=0/%h", ifu_rsp_err, ifu_rsp_instr, dataf(32'h8000_0200)); end
    checks++; if (ifu_no_outs !== 1'b0) begin failures++; $display("FAIL err_outs_busy got=%b exp=0", ifu_no_outs); end
    tick();
    checks++; if ({ifu_rsp_err, ifu_rsp_instr} !== {1'b1, dataf(32'h8000_0204)}) begin failures++; $display("FAIL err_second got=%b/%h exp=1/%h", ifu_rsp_err, ifu_rsp_instr, dataf(32'h8000_0204)); end
    tick(); ifu_rsp_ready = 1'b0; #1;
    checks++; if (ifu_no_outs !== 1'b1 || ifu_rsp_valid !== 1'b0) begin failures++; $display("FAIL err_drain got=%b/%b exp=1/0", ifu_no_outs, ifu_rsp_valid); end
  endtask

  task automatic test_reset_mid();
    fill_two(32'h8000_0300, 32'h8000_0304, 1'b0);
    #1;
    checks++; if (bus_rsp_ready !== 1'b0) begin failures++; $display("FAIL midrst_full got=%b exp=0", bus_rsp_ready); end
    rst = 1'b1; tick(); rst = 1'b0; #1;
    checks++; if (ifu_rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_rsp_valid got=%b exp=0", ifu_rsp_valid); end
    checks++; if (ifu_no_outs !== 1'b1) begin failures++; $display("FAIL midrst_no_outs got=%b exp=1", ifu_no_outs); end
    checks++; if (bus_rsp_ready !== 1'b1) begin failures++; $display("FAIL midrst_bus_rsp_ready got=%b exp=1", bus_rsp_ready); end
  endtask

  task automatic test_wrap();
    logic [31:0] pc [9];
    for (int k = 0; k < 9; k++) pc[k] = 32'h8000_1220 + 32'(k * 4);
    idle(); bus_cmd_ready = 1'b1; ifu_req_valid = 1'b1; ifu_req_pc = pc[0]; tick();
    ifu_req_valid = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = dataf(pc[0]); bus_rsp_err = errf(pc[0]); tick();
    for (int k = 1; k < 9; k++) begin
      bus_rsp_valid = 1'b0; ifu_rsp_ready = 1'b0; ifu_req_valid = 1'b1; ifu_req_pc = pc[k]; #1;
      checks++; if (ifu_req_ready !== 1'b1) begin failures++; $display("FAIL wrap_req_ready k=%0d got=%b exp=1", k, ifu_req_ready); end
      checks++; if ({ifu_rsp_err, ifu_rsp_instr} !== {errf(pc[k-1]), dataf(pc[k-1])}) begin failures++; $display("FAIL wrap_head k=%0d got=%b/%h exp=%b/%h", k, ifu_rsp_err, ifu_rsp_instr, errf(pc[k-1]), dataf(pc[k-1])); end
      tick();
      ifu_req_valid = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = dataf(pc[k]); bus_rsp_err = errf(pc[k]); ifu_rsp_ready = 1'b1; #1;
      checks++; if (bus_rsp_ready !== 1'b1) begin failures++; $display("FAIL wrap_bus_rsp_ready k=%0d got=%b exp=1", k, bus_rsp_ready); end
      tick();
    end
    bus_rsp_valid = 1'b0; ifu_rsp_ready = 1'b1; #1;
    checks++; if (ifu_rsp_instr !== dataf(pc[8])) begin failures++; $display("FAIL wrap_last got=%h exp=%h", ifu_rsp_instr, dataf(pc[8])); end
    tick(); ifu_rsp_ready = 1'b0; #1;
    checks++; if (ifu_no_outs !== 1'b1) begin failures++; $display("FAIL wrap_drain got=%b exp=1", ifu_no_outs); end
  endtask

  task automatic test_random();
    logic [31:0] bus_q [$];
    logic [32:0] exp_q [$];
    int avail, cnt;
    logic al, e_rdy, e_vld, bus_hsk, req_hsk, rsp_hsk;
    rst = 1'b1; idle(); tick(); rst = 1'b0;
    avail = 0;
    for (int n = 0; n < 4000; n++) begin
      ifu_req_valid = 1'($urandom_range(0, 1));
      ifu_req_pc = ($urandom() & 32'hFFFF_FFFC) | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      bus_cmd_ready = $urandom_range(0, 3) != 0;
      ifu_rsp_ready = $urandom_range(0, 2) != 0;
      bus_rsp_valid = bus_q.size() > 0 && $urandom_range(0, 1) == 1;
      bus_rsp_rdata = bus_q.size() > 0 ? dataf(bus_q[0]) : 32'h0;
      bus_rsp_err = bus_q.size() > 0 ? errf(bus_q[0]) : 1'b0;
      #1;
      cnt = exp_q.size();
      al = ifu_req_pc[1:0] == 2'b00;
      e_rdy = cnt < 2 && (al ? bus_cmd_ready : cnt == 0);
      e_vld = avail > 0 || (BYP && bus_rsp_valid);
      checks++; if (ifu_req_ready !== e_rdy) begin failures++; $display("FAIL rnd_req_ready n=%0d got=%b exp=%b", n, ifu_req_ready, e_rdy); end
      checks++; if (bus_cmd_valid !== (ifu_req_valid && al && cnt < 2)) begin failures++; $display("FAIL rnd_cmd_valid n=%0d got=%b exp=%b", n, bus_cmd_valid, ifu_req_valid && al && cnt < 2); end
      checks++; if (bus_cmd_addr !== ifu_req_pc) begin failures++; $display("FAIL rnd_cmd_addr n=%0d got=%h exp=%h", n, bus_cmd_addr, ifu_req_pc); end
      checks++; if (ifu_no_outs !== (cnt == 0)) begin failures++; $display("FAIL rnd_no_outs n=%0d got=%b exp=%b", n, ifu_no_outs, cnt == 0); end
      checks++; if (bus_rsp_ready !== (avail < 2)) begin failures++; $display("FAIL rnd_bus_rsp_ready n=%0d got=%b exp=%b", n, bus_rsp_ready, avail < 2); end
      checks++; if (ifu_rsp_valid !== e_vld) begin failures++; $display("FAIL rnd_rsp_valid n=%0d got=%b exp=%b", n, ifu_rsp_valid, e_vld); end
      if (e_vld && cnt > 0) begin
        checks++; if ({ifu_rsp_err, ifu_rsp_instr} !== exp_q[0]) begin failures++; $display("FAIL rnd_rsp_data n=%0d got=%b/%h exp=%b/%h", n, ifu_rsp_err, ifu_rsp_instr, exp_q[0][32], exp_q[0][31:0]); end
      end
      @(posedge clk);
      bus_hsk = bus_rsp_valid && avail < 2;
      rsp_hsk = e_vld && ifu_rsp_ready;
      req_hsk = ifu_req_valid && e_rdy;
      if (rsp_hsk && exp_q.size() > 0) void'(exp_q.pop_front());
      if (bus_hsk) void'(bus_q.pop_front());
      avail = avail + int'(bus_hsk) + int'(req_hsk && !al) - int'(rsp_hsk);
      if (req_hsk) begin
        exp_q.push_back(al ? {errf(ifu_req_pc), dataf(ifu_req_pc)} : {1'b1, 32'h0});
        if (al) bus_q.push_back(ifu_req_pc);
      end
      #1;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_misaligned();
    test_back_to_back();
    test_err();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
